// File: rtl/branch_pkg.sv
// Shared constants and helpers for the execute-stage branch resolver:
// B-type funct3 encodings, 2-bit predictor counter encodings and the
// saturating counter update used by the history table.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] WT  = 2'b10;  // weakly taken
    localparam logic [1:0] ST  = 2'b11;  // strongly taken

    // Move one step towards the resolved direction, pinned at the extremes.
    function automatic logic [1:0] sat_ctr_update(input logic [1:0] ctr,
                                                  input logic       taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) begin
                nxt = ctr + 2'd1;
            end else begin
                nxt = ST;
            end
        end else begin
            if (ctr != SNT) begin
                nxt = ctr - 2'd1;
            end else begin
                nxt = SNT;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters. The read port is
// combinational (fetch-time prediction = counter MSB); the write port
// updates one counter at the clock edge, so a same-cycle read of the entry
// being written returns the value from before the update.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = WNT,
    localparam int        IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_taken,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken,
    input  logic             i_we
);

    logic [1:0] r_ctr [BHT_DEPTH];

    assign o_rd_taken = r_ctr[i_rd_idx][1];

    // Counter array: reset every entry, otherwise train the addressed entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else if (i_we) begin
            r_ctr[i_wr_idx] <= sat_ctr_update(r_ctr[i_wr_idx], i_wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution. Evaluates all B-type conditions plus
// JAL/JALR, raises a registered one-cycle redirect whenever fetch went the
// wrong way, trains the 2-bit history table and keeps wrapping counts of
// resolved branches and branch mispredicts.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = WNT
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_if_pred_taken,
    input  logic            i_ex_valid,
    input  logic            i_ex_stall,
    input  logic            i_ex_is_branch,
    input  logic            i_ex_is_jal,
    input  logic            i_ex_is_jalr,
    input  logic [2:0]      i_ex_funct3,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_rs1,
    input  logic [XLEN-1:0] i_ex_rs2,
    input  logic [XLEN-1:0] i_ex_imm,
    input  logic            i_ex_pred_taken,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [XLEN-1:0] o_link_addr,
    output logic            o_br_illegal,
    output logic [XLEN-1:0] o_branch_count,
    output logic [XLEN-1:0] o_mispredict_count
);

    localparam int              IDX_W     = $clog2(BHT_DEPTH);
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [XLEN-1:0] INSN_LEN  = XLEN'(4);

    logic            w_fire;
    logic            w_cond_taken;
    logic            w_f3_legal;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_jalr_target;
    logic            w_redirect;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_link_we;
    logic            w_bht_we;
    logic            w_illegal;
    logic            w_br_inc;
    logic            w_mispred_inc;
    logic            w_unused;

    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic [XLEN-1:0] r_link_addr;
    logic            r_br_illegal;
    logic [XLEN-1:0] r_branch_count;
    logic [XLEN-1:0] r_mispredict_count;

    assign w_fire        = i_ex_valid & ~i_ex_stall &
                           (i_ex_is_branch | i_ex_is_jal | i_ex_is_jalr);
    assign w_pc_plus4    = i_ex_pc + INSN_LEN;
    assign w_br_target   = i_ex_pc + i_ex_imm;
    assign w_jalr_target = (i_ex_rs1 + i_ex_imm) & JALR_MASK;

    // Only the word-index bits of the fetch PC address the table.
    assign w_unused = ^{i_if_pc[1:0], i_if_pc[XLEN-1:IDX_W+2]};

    bht_2bit #(
        .BHT_DEPTH (BHT_DEPTH),
        .CTR_INIT  (CTR_INIT)
    ) u_bht (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rd_idx   (i_if_pc[IDX_W+1:2]),
        .o_rd_taken (o_if_pred_taken),
        .i_wr_idx   (i_ex_pc[IDX_W+1:2]),
        .i_wr_taken (w_cond_taken),
        .i_we       (w_bht_we)
    );

    // Branch condition evaluation; 010/011 are reserved and never taken.
    always_comb begin
        w_cond_taken = 1'b0;
        w_f3_legal   = 1'b1;
        case (i_ex_funct3)
            F3_BEQ:  w_cond_taken = (i_ex_rs1 == i_ex_rs2);
            F3_BNE:  w_cond_taken = (i_ex_rs1 != i_ex_rs2);
            F3_BLT:  w_cond_taken = ($signed(i_ex_rs1) <  $signed(i_ex_rs2));
            F3_BGE:  w_cond_taken = ($signed(i_ex_rs1) >= $signed(i_ex_rs2));
            F3_BLTU: w_cond_taken = (i_ex_rs1 <  i_ex_rs2);
            F3_BGEU: w_cond_taken = (i_ex_rs1 >= i_ex_rs2);
            default: begin
                w_cond_taken = 1'b0;
                w_f3_legal   = 1'b0;
            end
        endcase
    end

    // Resolution: pick the instruction class (jalr > jal > branch) and
    // decide redirect, link write, table training and counter increments.
    always_comb begin
        w_redirect    = 1'b0;
        w_redirect_pc = w_pc_plus4;
        w_link_we     = 1'b0;
        w_bht_we      = 1'b0;
        w_illegal     = 1'b0;
        w_br_inc      = 1'b0;
        w_mispred_inc = 1'b0;
        if (w_fire) begin
            if (i_ex_is_jalr) begin
                w_redirect    = 1'b1;
                w_redirect_pc = w_jalr_target;
                w_link_we     = 1'b1;
            end else if (i_ex_is_jal) begin
                w_redirect    = 1'b1;
                w_redirect_pc = w_br_target;
                w_link_we     = 1'b1;
            end else if (w_f3_legal) begin
                w_bht_we      = 1'b1;
                w_br_inc      = 1'b1;
                w_mispred_inc = (w_cond_taken != i_ex_pred_taken);
                w_redirect    = w_mispred_inc;
                w_redirect_pc = w_cond_taken ? w_br_target : w_pc_plus4;
            end else begin
                w_illegal     = 1'b1;
            end
        end else begin
            w_redirect    = 1'b0;
        end
    end

    // Output registers and performance counters; reset overrides any resolve.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_redirect_valid   <= 1'b0;
            r_redirect_pc      <= '0;
            r_link_addr        <= '0;
            r_br_illegal       <= 1'b0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_redirect_valid <= w_redirect;
            r_br_illegal     <= w_illegal;
            if (w_redirect) begin
                r_redirect_pc <= w_redirect_pc;
            end
            if (w_link_we) begin
                r_link_addr <= w_pc_plus4;
            end
            if (w_br_inc) begin
                r_branch_count <= r_branch_count + XLEN'(1);
            end
            if (w_mispred_inc) begin
                r_mispredict_count <= r_mispredict_count + XLEN'(1);
            end
        end
    end

    assign o_redirect_valid   = r_redirect_valid;
    assign o_redirect_pc      = r_redirect_pc;
    assign o_link_addr        = r_link_addr;
    assign o_br_illegal       = r_br_illegal;
    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized checks of branch_resolve_unit against an
// arithmetic reference model of the resolution rules and the history table.
module tb_branch_resolve_unit;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc, link_addr;
    logic        br_illegal;
    logic [31:0] branch_count, mispredict_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_ctr [DEPTH];
    logic [31:0] m_bc, m_mc, m_link;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_if_pc            (if_pc),
        .o_if_pred_taken    (if_pred_taken),
        .i_ex_valid         (ex_valid),
        .i_ex_stall         (ex_stall),
        .i_ex_is_branch     (ex_is_branch),
        .i_ex_is_jal        (ex_is_jal),
        .i_ex_is_jalr       (ex_is_jalr),
        .i_ex_funct3        (ex_funct3),
        .i_ex_pc            (ex_pc),
        .i_ex_rs1           (ex_rs1),
        .i_ex_rs2           (ex_rs2),
        .i_ex_imm           (ex_imm),
        .i_ex_pred_taken    (ex_pred_taken),
        .o_redirect_valid   (redirect_valid),
        .o_redirect_pc      (redirect_pc),
        .o_link_addr        (link_addr),
        .o_br_illegal       (br_illegal),
        .o_branch_count     (branch_count),
        .o_mispredict_count (mispredict_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int tbl_idx(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic bit cond_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return int'(a) <  int'(b);
            3'd5:    return int'(a) >= int'(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock of stimulus: drive, check the lookup, advance, check outputs.
    task automatic step(input logic rst, input logic v, input logic st,
                        input logic br, input logic jal, input logic jalr,
                        input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic pred,
                        input logic [31:0] ifpc);
        bit          fire, tk;
        logic        e_rv, e_ill;
        logic [31:0] e_rpc;
        @(negedge clk);
        reset = rst; ex_valid = v; ex_stall = st; ex_is_branch = br;
        ex_is_jal = jal; ex_is_jalr = jalr; ex_funct3 = f3; ex_pc = pc;
        ex_rs1 = a; ex_rs2 = b; ex_imm = imm; ex_pred_taken = pred; if_pc = ifpc;
        #1;
        chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, m_ctr[tbl_idx(ifpc)] >= 2});
        fire  = v && !st && (br || jal || jalr);
        e_rv  = 1'b0;
        e_ill = 1'b0;
        e_rpc = 32'd0;
        if (rst) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_bc = 32'd0; m_mc = 32'd0; m_link = 32'd0;
        end else if (fire) begin
            if (jalr) begin
                e_rv = 1'b1; e_rpc = (a + imm) & 32'hFFFF_FFFE; m_link = pc + 32'd4;
            end else if (jal) begin
                e_rv = 1'b1; e_rpc = pc + imm; m_link = pc + 32'd4;
            end else if (f3 == 3'd2 || f3 == 3'd3) begin
                e_ill = 1'b1;
            end else begin
                tk = cond_taken(f3, a, b);
                m_bc = m_bc + 32'd1;
                if (tk != pred) begin
                    m_mc  = m_mc + 32'd1;
                    e_rv  = 1'b1;
                    e_rpc = tk ? pc + imm : pc + 32'd4;
                end
                if (tk) m_ctr[tbl_idx(pc)] = (m_ctr[tbl_idx(pc)] == 3) ? 3 : m_ctr[tbl_idx(pc)] + 1;
                else    m_ctr[tbl_idx(pc)] = (m_ctr[tbl_idx(pc)] == 0) ? 0 : m_ctr[tbl_idx(pc)] - 1;
            end
        end
        @(posedge clk);
        #1;
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_rv});
        if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
        chk("br_illegal", {31'd0, br_illegal}, {31'd0, e_ill});
        chk("link_addr", link_addr, m_link);
        chk("branch_count", branch_count, m_bc);
        chk("mispredict_count", mispredict_count, m_mc);
    endtask

    initial begin
        logic [31:0] r, pc, a, b;
        foreach (m_ctr[i]) m_ctr[i] = 1;
        m_bc = 32'd0; m_mc = 32'd0; m_link = 32'd0;

        // reset, then idle lookups across every table entry
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'(i * 4));
            chk("idle_pred", {31'd0, if_pred_taken}, 32'd0);
        end

        // BEQ taken, predicted not-taken
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h100);
        chk("beq_rpc", redirect_pc, 32'h120);
        chk("beq_mc", mispredict_count, 32'd1);

        // BLT signed taken; BLTU same operands not taken, predicted taken
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 32'h180, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h180);
        chk("blt_rv", {31'd0, redirect_valid}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h200);
        chk("bltu_rpc", redirect_pc, 32'h204);

        // JALR target with bit 0 cleared, link written, branch count unchanged
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'h300, 32'h1001, 32'd0, 32'd2, 1'b0, 32'h300);
        chk("jalr_rpc", redirect_pc, 32'h1002);
        chk("jalr_link", link_addr, 32'h304);

        // train one entry to strongly taken, then back to weakly not-taken
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h400, 32'd7, 32'd7, 32'h10, 1'b1, 32'h400);
        #2 if_pc = 32'h400; #1 chk("sat_pred", {31'd0, if_pred_taken}, 32'd1);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h400, 32'd7, 32'd8, 32'h10, 1'b1, 32'h400);
        #2 if_pc = 32'h400; #1 chk("untrain_pred", {31'd0, if_pred_taken}, 32'd0);

        // reserved funct3, then a stalled taken branch
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h500, 32'd1, 32'd1, 32'h8, 1'b0, 32'h500);
        chk("illegal_pulse", {31'd0, br_illegal}, 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h500, 32'd1, 32'd1, 32'h8, 1'b0, 32'h500);

        // randomized traffic over a small PC window so table entries collide
        for (int n = 0; n < 500; n++) begin
            r  = $urandom;
            pc = $urandom & 32'h0000_03FC;
            a  = $urandom;
            b  = r[14] ? a : (r[15] ? $urandom : a + 32'd1);
            step(($urandom_range(0, 99) == 0), r[0] | r[1], r[3:2] == 2'd0,
                 r[4], r[7:5] == 3'd0, r[10:8] == 3'd0, r[13:11], pc, a, b,
                 $urandom, r[16], r[17] ? pc : ($urandom & 32'h0000_03FC));
        end

        // reset asserted on the same cycle as a mispredicting fire
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h600, 32'd3, 32'd3, 32'h20, 1'b0, 32'h600);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h600, 32'd3, 32'd3, 32'h20, 1'b0, 32'h600);
        chk("rst_fire_bc", branch_count, 32'd0);
        chk("rst_fire_rv", {31'd0, redirect_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
